// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer crossing blocks.
package fifo_pkg;

    // Legal synchronizer depth for any pointer receiver.
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Legal pointer width (address bits plus one wrap bit).
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // Number of set bits; used to measure the Hamming distance between Gray samples.
    function automatic int unsigned popcount(input logic [31:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt += 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary decoder, the inverse of the pointer encoder; purely combinational.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at and above it, which unrolls
    // b[i] = b[i+1] ^ g[i] without a bit-to-bit combinational chain on bin_o.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray pointer crossing: synchronize, decode, flag illegal
// multi-bit steps and derive fill level against the local binary pointer.
module gray_ptr_rx
    import fifo_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] gray_i,
    input  logic [WIDTH-1:0] local_bin_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] gray_sync_o,
    output logic [WIDTH-1:0] bin_o,
    output logic             update_o,
    output logic [WIDTH-1:0] step_o,
    output logic [WIDTH-1:0] level_o,
    output logic             empty_o,
    output logic             err_o
);

    // Reject unsupported configurations at elaboration.
    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
            $error("gray_ptr_rx: SYNC_STAGES must be within 2..4");
        end
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("gray_ptr_rx: WIDTH must be within 2..16");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]                  gray_prev_q;
    logic [WIDTH-1:0]                  gray_prev_d;
    logic [WIDTH-1:0]                  bin_q;
    logic [WIDTH-1:0]                  bin_d;
    logic [WIDTH-1:0]                  step_q;
    logic [WIDTH-1:0]                  step_d;
    logic                              update_q;
    logic                              update_d;
    logic                              err_q;
    logic                              err_d;
    logic [WIDTH-1:0]                  gray_sync;
    logic [WIDTH-1:0]                  decoded;
    logic                              illegal_step;

    // Only the last synchronizer stage is considered settled.
    assign gray_sync = sync_q[SYNC_STAGES-1];

    // Plain shift chain: stage 1 sees only gray_i, no logic between stages.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = gray_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .gray_i (gray_sync),
        .bin_o  (decoded)
    );

    // Register the decoded pointer; report a change and its modular distance.
    always_comb begin
        bin_d    = decoded;
        update_d = (decoded != bin_q);
        step_d   = step_q;
        if (update_d) begin
            step_d = decoded - bin_q;
        end
    end

    // A legal Gray stream moves at most one bit per sample; anything more is sticky.
    // A new violation overrides a simultaneous clear.
    always_comb begin
        gray_prev_d  = gray_sync;
        illegal_step = (popcount(32'(gray_sync ^ gray_prev_q)) >= 32'd2);
        err_d        = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (illegal_step) begin
            err_d = 1'b1;
        end
    end

    // All state clears asynchronously so no pipeline contents survive a reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q      <= '0;
            gray_prev_q <= '0;
            bin_q       <= '0;
            step_q      <= '0;
            update_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            gray_prev_q <= gray_prev_d;
            bin_q       <= bin_d;
            step_q      <= step_d;
            update_q    <= update_d;
            err_q       <= err_d;
        end
    end

    // Level keeps the wrap bit, so a full FIFO reads 2^(WIDTH-1); no saturation.
    assign level_o     = bin_q - local_bin_i;
    assign empty_o     = (bin_q == local_bin_i);
    assign gray_sync_o = gray_sync;
    assign bin_o       = bin_q;
    assign step_o      = step_q;
    assign update_o    = update_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Self-checking bench for gray_ptr_rx: directed steps plus random pointer traffic
// compared against a history-based reference model.
module tb_gray_ptr_rx;

    localparam int W   = 4;
    localparam int S   = 2;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n_i;
    logic [W-1:0] gray_i;
    logic [W-1:0] local_bin_i;
    logic         err_clr_i;
    logic [W-1:0] gray_sync_o;
    logic [W-1:0] bin_o;
    logic         update_o;
    logic [W-1:0] step_o;
    logic [W-1:0] level_o;
    logic         empty_o;
    logic         err_o;

    always #5 clk = ~clk;

    gray_ptr_rx #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .gray_i      (gray_i),
        .local_bin_i (local_bin_i),
        .err_clr_i   (err_clr_i),
        .gray_sync_o (gray_sync_o),
        .bin_o       (bin_o),
        .update_o    (update_o),
        .step_o      (step_o),
        .level_o     (level_o),
        .empty_o     (empty_o),
        .err_o       (err_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: hist[k] is the gray_i value sampled k edges ago (0 before reset release).
    logic [W-1:0] hist[$];
    int m_bin, m_step, m_update, m_err;

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    function automatic int decode(input int g);
        for (int b = 0; b < MOD; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back('0);
        m_bin    = 0;
        m_step   = 0;
        m_update = 0;
        m_err    = 0;
    endtask

    task automatic model_edge();
        int nb, ob;
        hist.push_front(gray_i);
        void'(hist.pop_back());
        nb       = decode(int'(hist[S]));
        ob       = decode(int'(hist[S+1]));
        m_update = (nb != ob) ? 1 : 0;
        if (nb != ob) m_step = (nb - ob + MOD) % MOD;
        m_bin = nb;
        if (err_clr_i) m_err = 0;
        if ($countones(hist[S] ^ hist[S+1]) >= 2) m_err = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int lvl;
        lvl = (m_bin - int'(local_bin_i) + MOD) % MOD;
        chk({ph, ".gray_sync"}, 32'(gray_sync_o), 32'(hist[S-1]));
        chk({ph, ".bin"},       32'(bin_o),       m_bin);
        chk({ph, ".update"},    32'(update_o),    m_update);
        chk({ph, ".step"},      32'(step_o),      m_step);
        chk({ph, ".level"},     32'(level_o),     lvl);
        chk({ph, ".empty"},     32'(empty_o),     (lvl == 0) ? 1 : 0);
        chk({ph, ".err"},       32'(err_o),       m_err);
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        if (!rst_n_i) model_reset();
        else          model_edge();
        #1;
        check_all(ph);
    endtask

    initial begin
        int cur;
        int r;

        // Reset held with a non-zero foreign pointer.
        rst_n_i     = 1'b0;
        gray_i      = 4'b1010;
        local_bin_i = '0;
        err_clr_i   = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        repeat (3) tick("reset_hold");
        rst_n_i = 1'b1;
        tick("release");
        tick("release");
        chk("release_bin_pre", 32'(bin_o), 0);
        tick("release");
        chk("release_bin",    32'(bin_o),    32'd12);
        chk("release_update", 32'(update_o), 1);
        chk("release_step",   32'(step_o),   32'd12);
        tick("release");
        chk("release_update_pulse", 32'(update_o), 0);

        // Count sequence 0..15 then wrap to 0, one value per 4 cycles.
        local_bin_i = '0;
        for (int i = 0; i <= 16; i++) begin
            gray_i = W'(gray_of(i % MOD));
            repeat (4) tick("count");
            chk("count_bin", 32'(bin_o), i % MOD);
        end

        // Illegal two-bit step from a stable 0000.
        gray_i = '0;
        repeat (4) tick("ill_settle");
        err_clr_i = 1'b1;
        tick("ill_clr");
        err_clr_i = 1'b0;
        chk("ill_err_cleared", 32'(err_o), 0);
        gray_i = 4'b0011;
        tick("ill");
        tick("ill");
        chk("ill_err_pre", 32'(err_o), 0);
        tick("ill");
        chk("ill_bin", 32'(bin_o), 2);
        chk("ill_err", 32'(err_o), 1);
        gray_i = 4'b0010;
        repeat (4) tick("ill_hold");
        gray_i = 4'b0110;
        repeat (4) tick("ill_hold");
        chk("ill_err_sticky", 32'(err_o), 1);

        // Clear without a violation, then clear coinciding with a violation.
        err_clr_i = 1'b1;
        tick("clr");
        err_clr_i = 1'b0;
        chk("clr_err", 32'(err_o), 0);
        gray_i = 4'b0000;
        tick("clr_set");
        tick("clr_set");
        err_clr_i = 1'b1;
        tick("clr_set");
        err_clr_i = 1'b0;
        chk("clr_vs_set_err", 32'(err_o), 1);

        // Level and empty across the wrap.
        gray_i = 4'b0011;
        repeat (4) tick("level");
        local_bin_i = 4'd14;
        #1;
        check_all("level_wrap");
        chk("level_wrap_val",   32'(level_o), 4);
        chk("level_wrap_empty", 32'(empty_o), 0);
        local_bin_i = 4'd2;
        #1;
        check_all("level_eq");
        chk("level_eq_val",   32'(level_o), 0);
        chk("level_eq_empty", 32'(empty_o), 1);

        // Random pointer traffic: mostly legal +/-1 steps, occasional jumps.
        cur = decode(int'(gray_i));
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 10)       cur = (cur + (($urandom_range(0, 1) == 1) ? 1 : MOD - 1)) % MOD;
            else if (r == 10) cur = int'($urandom_range(0, MOD - 1));
            gray_i      = W'(gray_of(cur));
            local_bin_i = W'($urandom_range(0, MOD - 1));
            err_clr_i   = ($urandom_range(0, 7) == 0);
            tick("rand");
        end
        err_clr_i = 1'b0;

        // Reset mid-stream with the error flag set.
        gray_i = W'(gray_of(5));
        repeat (4) tick("mid_pre");
        gray_i = '0;
        repeat (4) tick("mid_pre");
        chk("mid_err_set", 32'(err_o), 1);
        for (int i = 1; i <= 3; i++) begin
            gray_i = W'(gray_of(i));
            tick("mid_count");
        end
        #3;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check_all("mid_async");
        chk("mid_async_bin", 32'(bin_o), 0);
        chk("mid_async_err", 32'(err_o), 0);
        tick("mid_hold");
        rst_n_i = 1'b1;
        gray_i  = W'(gray_of(9));
        tick("mid_resume");
        tick("mid_resume");
        chk("mid_resume_bin_pre", 32'(bin_o), 0);
        tick("mid_resume");
        chk("mid_resume_bin", 32'(bin_o), 9);
        for (int i = 10; i < 14; i++) begin
            gray_i = W'(gray_of(i));
            repeat (4) tick("mid_track");
            chk("mid_track_bin", 32'(bin_o), i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
